// File: rtl/mux2_1_pkg.sv
// Shared definitions for the 2:1 selector: default width and the select function
// used by both the combinational and the registered paths.
package mux2_1_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int MAX_WIDTH     = 64;

  // Operands are zero-extended to MAX_WIDTH by the caller; s=0 picks a, s=1 picks b.
  function automatic logic [MAX_WIDTH-1:0] sel2(
    input logic                 s,
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b
  );
    return s ? b : a;
  endfunction

endpackage

// File: rtl/mux2_1_skid.sv
// Two-entry valid/ready skid buffer: an output register plus one skid register.
// in_ready comes straight from a flop, so y_ready never reaches it combinationally.
module mux2_1_skid #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic             skid_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      skid_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
    end else if (!out_valid_reg || out_ready) begin
      // Output register is free this edge; the skid entry is older, so it goes first.
      if (skid_valid_reg) begin
        out_data_reg   <= skid_data_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (in_valid) begin
        out_data_reg  <= in_data;
        out_valid_reg <= 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (in_valid && !skid_valid_reg) begin
      skid_data_reg  <= in_data;
      skid_valid_reg <= 1'b1;
    end
  end

  assign in_ready  = !skid_valid_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: rtl/mux2_1.sv
// 2:1 selector with a zero-latency combinational output and a registered
// valid/ready output backed by a two-entry skid buffer.
module mux2_1
  import mux2_1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y_comb,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);

  logic [MAX_WIDTH-1:0] sel_wide;
  logic [WIDTH-1:0]     sel_word;

  assign sel_wide = sel2(s, MAX_WIDTH'(i0), MAX_WIDTH'(i1));
  assign sel_word = WIDTH'(sel_wide);
  assign y_comb   = sel_word;

  mux2_1_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (sel_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (y),
    .out_valid (y_valid),
    .out_ready (y_ready)
  );

endmodule

// File: tb/tb_mux2_1.sv
// Bench for mux2_1: a queue model of the two-entry buffer predicts y/y_valid/in_ready,
// and the combinational output is checked directly against the select rule.
module tb_mux2_1;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] i0, i1;
  logic         s, in_valid, y_ready;
  logic         in_ready, y_valid;
  logic [W-1:0] y_comb, y;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] out_log[$];

  mux2_1 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i0       (i0),
    .i1       (i1),
    .s        (s),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y_comb   (y_comb),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready)
  );

  always #5 clk = ~clk;

  // Reference: the block holds at most two words in order; y shows the oldest.
  always @(posedge clk or negedge rst_n) begin : model
    bit acc, drn;
    if (!rst_n) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      drn = (q.size() != 0) && y_ready;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(s ? i1 : i0);
    end
  end

  always @(posedge clk) begin
    if (rst_n && y_valid && y_ready) out_log.push_back(y);
  end

  task automatic test_reset();
    rst_n = 1'b0; i0 = 8'h3C; i1 = 8'hC3; s = 1'b1; in_valid = 1'b0; y_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (y !== 8'h00 || y_valid !== 1'b0 || in_ready !== 1'b1 || y_comb !== 8'hC3) begin
      failures++;
      $display("FAIL reset: got y=%h y_valid=%b in_ready=%b y_comb=%h, want y=00 y_valid=0 in_ready=1 y_comb=c3",
               y, y_valid, in_ready, y_comb);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_comb_select();
    logic [W-1:0] exp_c;
    i0 = 8'h00; i1 = 8'h01; in_valid = 1'b0; y_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s = k[0];
      exp_c = (k % 2 == 1) ? 8'h01 : 8'h00;
      #1;
      checks++;
      if (y_comb !== exp_c) begin
        failures++;
        $display("FAIL comb_select k=%0d: got y_comb=%h want %h", k, y_comb, exp_c);
      end
      @(negedge clk);
    end
    // y_comb keeps following s while reset is held
    rst_n = 1'b0; s = 1'b1; #1;
    checks++;
    if (y_comb !== 8'h01) begin
      failures++;
      $display("FAIL comb_in_reset: got y_comb=%h want 01", y_comb);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    logic [W-1:0] exp_y;
    logic         exp_v, exp_r;
    y_ready = 1'b1; in_valid = 1'b1; i0 = 8'h11; i1 = 8'h22;
    for (int k = 0; k < 4; k++) begin
      s = (k == 0);
      in_valid = (k < 2);
      @(posedge clk); @(negedge clk);
      exp_v = (q.size() != 0); exp_r = (q.size() < 2); exp_y = exp_v ? q[0] : '0;
      checks++;
      if (y_valid !== exp_v || in_ready !== exp_r || (exp_v && y !== exp_y)) begin
        failures++;
        $display("FAIL pass_through k=%0d: got y=%h y_valid=%b in_ready=%b, want y=%h y_valid=%b in_ready=%b",
                 k, y, y_valid, in_ready, exp_y, exp_v, exp_r);
      end
    end
    checks++;
    if (out_log.size() != 2 || out_log[0] !== 8'h22 || out_log[1] !== 8'h11) begin
      failures++;
      $display("FAIL pass_through_order: got %0d words, want 22 then 11", out_log.size());
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] words [3];
    logic [W-1:0] exp_y;
    logic         exp_v, exp_r;
    int           idx = 0;
    bit           took;
    words[0] = 8'hA1; words[1] = 8'hA2; words[2] = 8'hA3;
    out_log.delete();
    y_ready = 1'b0; s = 1'b1; i0 = 8'h00;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (idx < 3);
      i1 = words[idx < 3 ? idx : 2];
      y_ready = (cyc >= 3);
      took = in_valid && in_ready;
      @(posedge clk);
      if (took) idx++;
      @(negedge clk);
      exp_v = (q.size() != 0); exp_r = (q.size() < 2); exp_y = exp_v ? q[0] : '0;
      checks++;
      if (y_valid !== exp_v || in_ready !== exp_r || (exp_v && y !== exp_y)) begin
        failures++;
        $display("FAIL backpressure cyc=%0d: got y=%h y_valid=%b in_ready=%b, want y=%h y_valid=%b in_ready=%b",
                 cyc, y, y_valid, in_ready, exp_y, exp_v, exp_r);
      end
      if (cyc == 2) begin
        checks++;
        if (in_ready !== 1'b0 || y !== 8'hA1 || y_valid !== 1'b1) begin
          failures++;
          $display("FAIL backpressure_full: got y=%h y_valid=%b in_ready=%b, want y=a1 y_valid=1 in_ready=0",
                   y, y_valid, in_ready);
        end
      end
    end
    checks++;
    if (idx != 3 || out_log.size() != 3 || out_log[0] !== 8'hA1 || out_log[1] !== 8'hA2 || out_log[2] !== 8'hA3) begin
      failures++;
      $display("FAIL backpressure_order: got sent=%0d drained=%0d, want sent=3 drained a1,a2,a3",
               idx, out_log.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_y;
    in_valid = 1'b1; y_ready = 1'b0; s = 1'b0; i0 = 8'h40;
    @(posedge clk); @(negedge clk);
    y_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i0 = W'($urandom); i1 = W'($urandom); s = 1'($urandom);
      @(posedge clk); @(negedge clk);
      exp_y = (q.size() != 0) ? q[0] : '0;
      checks++;
      if (y_valid !== 1'b1 || in_ready !== 1'b1 || q.size() != 1 || y !== exp_y) begin
        failures++;
        $display("FAIL back_to_back k=%0d: got y=%h y_valid=%b in_ready=%b, want y=%h y_valid=1 in_ready=1",
                 k, y, y_valid, in_ready, exp_y);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; y_ready = 1'b0; s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i0 = 8'hB0 + W'(k);
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 8'h00 || y_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: got y=%h y_valid=%b in_ready=%b, want y=00 y_valid=0 in_ready=1",
               y, y_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; y_ready = 1'b1; s = 1'b1; i1 = 8'h5A;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (y !== 8'h5A || y_valid !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL after_reset: got y=%h y_valid=%b in_ready=%b, want y=5a y_valid=1 in_ready=1",
               y, y_valid, in_ready);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_exhaustive();
    logic [W-1:0] exp_c, exp_y;
    logic         exp_v;
    y_ready = 1'b1; in_valid = 1'b1;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int sel = 0; sel < 2; sel++) begin
          i0 = W'(a); i1 = W'(b); s = sel[0];
          exp_c = (sel == 1) ? W'(b) : W'(a);
          #1;
          checks++;
          if (y_comb !== exp_c) begin
            failures++;
            $display("FAIL exhaustive_comb a=%0d b=%0d s=%0d: got y_comb=%h want %h", a, b, sel, y_comb, exp_c);
          end
          @(posedge clk); @(negedge clk);
          exp_v = (q.size() != 0); exp_y = exp_v ? q[0] : '0;
          checks++;
          if (y_valid !== 1'b1 || exp_v !== 1'b1 || y !== exp_c || y !== exp_y) begin
            failures++;
            $display("FAIL exhaustive_reg a=%0d b=%0d s=%0d: got y=%h y_valid=%b want y=%h y_valid=1",
                     a, b, sel, y, y_valid, exp_c);
          end
        end
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] exp_y;
    logic         exp_v, exp_r;
    for (int k = 0; k < 303; k++) begin
      in_valid = (k < 300) ? 1'($urandom) : 1'b0;
      y_ready  = (k < 300) ? ($urandom_range(0, 3) != 0) : 1'b1;
      i0 = W'($urandom); i1 = W'($urandom); s = 1'($urandom);
      @(posedge clk); @(negedge clk);
      exp_v = (q.size() != 0); exp_r = (q.size() < 2); exp_y = exp_v ? q[0] : '0;
      checks++;
      if (y_valid !== exp_v || in_ready !== exp_r || (exp_v && y !== exp_y)) begin
        failures++;
        $display("FAIL random k=%0d: got y=%h y_valid=%b in_ready=%b, want y=%h y_valid=%b in_ready=%b",
                 k, y, y_valid, in_ready, exp_y, exp_v, exp_r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_comb_select();
    test_pass_through();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_exhaustive();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux2_1.md
Name: mux2_1

Overview:
- 2:1 selector.
- Chooses between data inputs i0 and i1 under select s.
- Provides a zero-latency combinational output y_comb for glue logic.
- Provides a registered, flow-controlled output y (valid/ready) for pipelined datapaths.
- Used wherever a datapath stage picks one of two sources; single clock domain.

Parameters:
- WIDTH, 1, data width of i0, i1, y_comb and y in bits (legal: 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- i0  input  WIDTH  data source selected when s=0.
- i1  input  WIDTH  data source selected when s=1.
- s  input  1  select; 0 -> i0, 1 -> i1.
- in_valid  input  1  i0/i1/s form a valid transfer this cycle.
- in_ready  output  1  block can accept a transfer this cycle.
- y_comb  output  WIDTH  combinational result, s ? i1 : i0.
- y  output  WIDTH  registered result.
- y_valid  output  1  y holds a valid result.
- y_ready  input  1  downstream accepts y this cycle.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- y_comb:
  - y_comb = s ? i1 : i0, bitwise, purely combinational.
  - Independent of clk, rst_n, in_valid and handshakes.
  - Changes in the same delta as s/i0/i1.
- Input transfer: occurs on a rising clk edge when in_valid && in_ready. Captured value is s ? i1 : i0 sampled at that edge.
- Output transfer: occurs on a rising clk edge when y_valid && y_ready.
- Latency and throughput:
  - Accepted transfer appears on y with y_valid=1 one cycle later (next edge), if the output register is empty or being drained that edge.
  - Throughput: one transfer per cycle while y_ready=1.
- Storage: 2-entry skid structure (output register plus one skid register).
  - in_ready is registered, so there is no combinational path from y_ready to in_ready.
  - in_ready=1 when the skid register is empty.
  - When the output is stalled (y_valid=1, y_ready=0) and a transfer is accepted, data goes to the skid register and in_ready drops to 0 on the next cycle.
  - When y is consumed and the skid is full: skid data moves into y, and in_ready returns to 1 the following cycle.
- Ordering: strict FIFO order; no drop, no duplication.
- Simultaneous accept and drain:
  - Output register refills from the skid if occupied, else from the new input.
  - Occupancy is unchanged.
- Stability: y and y_valid hold stable while y_valid=1 and y_ready=0.
- Reset (asynchronous assert, synchronous release):
  - y=0, y_valid=0, skid empty, in_ready=1.
  - Applies immediately on rst_n falling, mid-stream included.
  - In-flight data is discarded.
  - y_comb is unaffected by reset.
- Idle inputs: in_valid=0 leaves registered state unchanged apart from draining. Values of s, i0, i1 are don't-care for the registered path when in_valid=0.

Decomposition:
- Package mux2_1_pkg:
  - localparam DEFAULT_WIDTH = 1.
  - Function sel2(s, a, b) returning the selected word, shared by the comb and registered paths.
- Sub-module mux2_1_skid (WIDTH): a generic 2-entry valid/ready skid buffer with async active-low reset.
- mux2_1 instantiates mux2_1_skid and feeds it sel2(s, i0, i1).

Test Plan:
- Comb select: WIDTH=1, i0=0, i1=1, s=0 at t=0, toggled every 10 ns -> y_comb = 0, 1, 0 at t = 5, 15, 25 ns; held through reset assertion.
- Registered pass-through: WIDTH=8, y_ready=1, in_valid=1 with (i0=0x11, i1=0x22, s=1) then (s=0) -> y=0x22 one cycle after the first accept, then 0x11; y_valid high two cycles.
- Backpressure: y_ready=0, send 0xA1, 0xA2, 0xA3 on consecutive cycles -> 0xA1 in y, 0xA2 in skid, in_ready=0, 0xA3 held by source. Release y_ready -> y shows 0xA1, 0xA2, 0xA3 in order, none lost.
- Simultaneous accept/drain: y_valid=1, y_ready=1, in_valid=1 every cycle for 10 cycles -> y_valid stays 1, one new word per cycle, in_ready stays 1.
- Async reset mid-stream: skid full, pull rst_n low between edges -> immediately y=0, y_valid=0, in_ready=1. After release, the first accepted word appears on the next cycle.
- Exhaustive select: WIDTH=4, all 16x16x2 i0/i1/s combinations -> y_comb and y (one cycle later) match s ? i1 : i0.
